// File: rtl/print_pkg.sv
// Token types shared by the matrix print sequencer and the ASCII packer.
// The packer decodes these same codes from its input handshake.
package print_pkg;

    typedef logic [1:0] tok_type_t;

    localparam tok_type_t TOK_NUMBER  = 2'd0;
    localparam tok_type_t TOK_SPACE   = 2'd1;
    localparam tok_type_t TOK_NEWLINE = 2'd2;
    localparam tok_type_t TOK_CHAR    = 2'd3;

endpackage

// File: rtl/matrix_print_sequencer.sv
// Walks a row-major matrix in RAM and emits number/space/newline tokens.
// Every output is a register loaded from the next-state logic below.
module matrix_print_sequencer
    import print_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int DIM_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [31:0]           tok_data,
    output tok_type_t             tok_type,
    output logic                  tok_valid,
    input  logic                  tok_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        EMIT_NUM,
        EMIT_SEP,
        FINISH
    } state_t;

    localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] ptr, ptr_d;
    logic [DIM_WIDTH-1:0]  row, row_d, col, col_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d;
    logic                  mem_rd_en_d, tok_valid_d, busy_d, done_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [31:0]           tok_data_d;
    tok_type_t             tok_type_d;
    logic                  last_col, last_row, xfer;

    assign last_col = (col == cols_q - DIM_ONE);
    assign last_row = (row == rows_q - DIM_ONE);
    assign xfer     = tok_valid && tok_ready;

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        row_d       = row;
        col_d       = col;
        rows_d      = rows_q;
        cols_d      = cols_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr;
        tok_data_d  = tok_data;
        tok_type_d  = tok_type;
        tok_valid_d = tok_valid;
        done_d      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    rows_d = rows;
                    cols_d = cols;
                    row_d  = '0;
                    col_d  = '0;
                    ptr_d  = base_addr;
                    if (rows == '0 || cols == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = READ;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = base_addr;
                    end
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                tok_data_d  = 32'(mem_rd_data);
                tok_type_d  = TOK_NUMBER;
                tok_valid_d = 1'b1;
                state_d     = EMIT_NUM;
            end
            EMIT_NUM: begin
                if (xfer) begin
                    tok_data_d = '0;
                    tok_type_d = last_col ? TOK_NEWLINE : TOK_SPACE;
                    state_d    = EMIT_SEP;
                end
            end
            EMIT_SEP: begin
                if (xfer) begin
                    tok_valid_d = 1'b0;
                    tok_type_d  = TOK_NUMBER;
                    ptr_d       = ptr + ADDR_ONE;
                    if (last_col && last_row) begin
                        col_d   = '0;
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        // Row advance only happens on the last column.
                        if (last_col) begin
                            col_d = '0;
                            row_d = row + DIM_ONE;
                        end else begin
                            col_d = col + DIM_ONE;
                        end
                        state_d     = READ;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = ptr + ADDR_ONE;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            row       <= '0;
            col       <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            tok_data  <= '0;
            tok_type  <= TOK_NUMBER;
            tok_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            row       <= row_d;
            col       <= col_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            mem_rd_en <= mem_rd_en_d;
            mem_addr  <= mem_addr_d;
            tok_data  <= tok_data_d;
            tok_type  <= tok_type_d;
            tok_valid <= tok_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_matrix_print_sequencer.sv
// Bench: expected tokens and read addresses come from a row/column walk
// over a RAM model; a negedge monitor compares the DUT against them.
module tb_matrix_print_sequencer;
    import print_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] base_addr = '0;
    logic [3:0]  rows = '0;
    logic [3:0]  cols = '0;
    logic        mem_rd_en;
    logic [13:0] mem_addr;
    logic [31:0] mem_rd_data = '0;
    logic [31:0] tok_data;
    tok_type_t   tok_type;
    logic        tok_valid;
    logic        tok_ready = 1'b1;
    logic        busy;
    logic        done;

    matrix_print_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .rows        (rows),
        .cols        (cols),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .tok_data    (tok_data),
        .tok_type    (tok_type),
        .tok_valid   (tok_valid),
        .tok_ready   (tok_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:16383];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [33:0] exp_tok[$];
    logic [13:0] exp_addr[$];
    int first_rd, first_valid, last_xfer, done_cyc, done_cnt, start_cyc;
    int ready_mode = 0;
    logic        stall_prev = 1'b0;
    logic [33:0] prev_tok = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        tok_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (mem_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
                else check("rd_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
            end
            if (stall_prev) begin
                check("stall_valid", 64'(tok_valid), 1);
                check("stall_token", 64'({tok_type, tok_data}), 64'(prev_tok));
            end
            if (tok_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (tok_ready) begin
                    if (exp_tok.size() == 0) check("unexpected_token", 1, 0);
                    else check("token", 64'({tok_type, tok_data}),
                               64'(exp_tok.pop_front()));
                    last_xfer = cyc;
                end
            end
            stall_prev = tok_valid && !tok_ready;
            prev_tok   = {tok_type, tok_data};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_print(input logic [13:0] b, input int r, input int c,
                               input int rmode);
        exp_tok.delete();
        exp_addr.delete();
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                logic [13:0] a;
                a = 14'(int'(b) + i * c + j);
                exp_addr.push_back(a);
                exp_tok.push_back({TOK_NUMBER, mem[a]});
                exp_tok.push_back({(j == c - 1) ? TOK_NEWLINE : TOK_SPACE, 32'd0});
            end
        end
        first_rd    = -1;
        first_valid = -1;
        last_xfer   = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        ready_mode  = rmode;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        rows      = 4'(r);
        cols      = 4'(c);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = 14'($urandom);
        rows      = 4'($urandom);
        cols      = 4'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("done_seen", 64'(done_cnt != 0), 1);
        @(negedge clk);
        #1;
        check("busy_after", 64'(busy), 0);
        check("done_once", 64'(done_cnt), 1);
        check("tokens_left", 64'(exp_tok.size()), 0);
        check("reads_left", 64'(exp_addr.size()), 0);
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, 64'({tok_valid, tok_data, tok_type, mem_rd_en,
                         mem_addr, busy, done}), 0);
    endtask

    initial begin
        logic [33:0] pin [0:11];
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        #1;
        check_idle_outputs("reset_outputs");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2x3 at 0x0010 holding 1..6 with ready held high.
        for (int i = 0; i < 6; i++) mem[16 + i] = 32'(i + 1);
        pin = '{ {TOK_NUMBER, 32'd1}, {TOK_SPACE, 32'd0},
                 {TOK_NUMBER, 32'd2}, {TOK_SPACE, 32'd0},
                 {TOK_NUMBER, 32'd3}, {TOK_NEWLINE, 32'd0},
                 {TOK_NUMBER, 32'd4}, {TOK_SPACE, 32'd0},
                 {TOK_NUMBER, 32'd5}, {TOK_SPACE, 32'd0},
                 {TOK_NUMBER, 32'd6}, {TOK_NEWLINE, 32'd0} };
        start_print(14'h0010, 2, 3, 0);
        for (int i = 0; i < 12; i++) check("model_2x3", 64'(exp_tok[i]), 64'(pin[i]));
        check("model_2x3_addr0", 64'(exp_addr[0]), 64'h10);
        check("model_2x3_addr5", 64'(exp_addr[5]), 64'h15);
        check("busy_started", 64'(busy), 1);
        wait_done();
        check("lat_first_rd", 64'(first_rd - start_cyc), 1);
        check("lat_first_valid", 64'(first_valid - start_cyc), 3);
        check("lat_last_xfer", 64'(last_xfer - start_cyc), 24);
        check("lat_done", 64'(done_cyc - start_cyc), 25);

        // 1x1 all-ones element.
        mem[14'h0050] = 32'hFFFF_FFFF;
        start_print(14'h0050, 1, 1, 0);
        check("model_1x1", 64'(exp_tok[0]), 64'({TOK_NUMBER, 32'hFFFF_FFFF}));
        wait_done();

        // Zero rows: no reads, no tokens, done right after IDLE->FINISH.
        start_print(14'h0123, 0, 5, 0);
        wait_done();
        check("zero_no_read", 64'(first_rd), 64'(-1));
        check("zero_no_valid", 64'(first_valid), 64'(-1));
        check("zero_done_lat", 64'(done_cyc - start_cyc), 1);

        // 2x2 under random backpressure.
        start_print(14'h0200, 2, 2, 1);
        wait_done();

        // Address wrap at the top of the RAM.
        start_print(14'h3FFE, 1, 4, 0);
        check("model_wrap2", 64'(exp_addr[2]), 64'h0000);
        check("model_wrap3", 64'(exp_addr[3]), 64'h0001);
        wait_done();

        // Random shapes, random backpressure.
        for (int k = 0; k < 6; k++) begin
            start_print(14'($urandom), $urandom_range(1, 4),
                        $urandom_range(1, 4), 1);
            wait_done();
        end

        // Second start mid-print is ignored, then reset mid-row.
        start_print(14'h0100, 2, 3, 1);
        repeat (6) @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 14'h0300;
        rows      = 4'd1;
        cols      = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset_outputs");
        check("no_done_before_reset", 64'(done_cnt), 0);
        exp_tok.delete();
        exp_addr.delete();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset_held_outputs");
        rst_n = 1'b1;
        start_print(14'h0100, 2, 3, 1);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
